// File: rtl/cache_stats_pkg.sv
// rtl/cache_stats_pkg.sv - shared types and default sizing for the cache hit-ratio reporter
package cache_stats_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int RATIO_W_DEF = 14;
  localparam int SCALE_DEF   = 10000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    DONE
  } state_e;

  // Dividend width: a counter times a scale that fits in the ratio field.
  function automatic int prod_w(input int cnt_w, input int ratio_w);
    return cnt_w + ratio_w;
  endfunction

endpackage

// File: rtl/cache_stats_if.sv
// rtl/cache_stats_if.sv - request/result bus between the counter source, cache_stats and the report logic
interface cache_stats_if
  import cache_stats_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF
);

  logic               start_valid;
  logic               start_ready;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;
  logic [CNT_W-1:0]   read_cnt;
  logic               res_valid;
  logic               res_ready;
  logic [RATIO_W-1:0] ratio_bp;
  logic [CNT_W-1:0]   hits_q;
  logic [CNT_W-1:0]   misses_q;
  logic [CNT_W-1:0]   reads_q;
  logic               err_zero;
  logic               err_range;
  logic               err_mismatch;

  modport master (
    output start_valid, hit_cnt, miss_cnt, read_cnt, res_ready,
    input  start_ready, res_valid, ratio_bp, hits_q, misses_q, reads_q,
           err_zero, err_range, err_mismatch
  );

  modport slave (
    input  start_valid, hit_cnt, miss_cnt, read_cnt, res_ready,
    output start_ready, res_valid, ratio_bp, hits_q, misses_q, reads_q,
           err_zero, err_range, err_mismatch
  );

endinterface

// File: rtl/stats_divider.sv
// rtl/stats_divider.sv - serial restoring divider, one quotient bit per cycle, MSB first
module stats_divider #(
  parameter int CNT_W  = 32,
  parameter int PROD_W = 46
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic [PROD_W-1:0] quotient,
  output logic              done
);

  localparam int                STEP_W    = $clog2(PROD_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PROD_W - 1);

  logic              busy;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  rem;
  logic [PROD_W-1:0] dvd_sh;
  logic [PROD_W-1:0] quo;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    rem_nx;
  logic              q_bit;

  // The held remainder is always below the divisor, so CNT_W bits hold it
  // and the shifted trial value needs just one more.
  always_comb begin
    rem_sh = {rem, dvd_sh[PROD_W-1]};
    q_bit  = (rem_sh >= {1'b0, divisor});
    rem_nx = q_bit ? (rem_sh - {1'b0, divisor}) : rem_sh;
  end

  // quotient includes the bit resolved this cycle, so the caller can capture
  // the final value on the same edge that done is seen.
  assign quotient = PROD_W'({quo, q_bit});
  assign done     = busy && (step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      step   <= '0;
      rem    <= '0;
      dvd_sh <= '0;
      quo    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      step   <= '0;
      rem    <= '0;
      dvd_sh <= dividend;
      quo    <= '0;
    end else if (busy) begin
      rem    <= CNT_W'(rem_nx);
      dvd_sh <= dvd_sh << 1;
      quo    <= quotient;
      step   <= step + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_stats.sv
// rtl/cache_stats.sv - snapshots cache hit/miss/read counters, checks them, returns hit ratio in basis points
// Define CACHE_STATS_PRINT_EN for a simulation-only summary print on entry to DONE.
module cache_stats
  import cache_stats_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int SCALE   = SCALE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_stats_if.slave bus
);

  localparam int PROD_W = prod_w(CNT_W, RATIO_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   snap_hits, snap_misses, snap_reads;
  logic [RATIO_W-1:0] ratio_r, ratio_d;
  logic               err_zero_r, err_range_r, err_mismatch_r;
  logic               capture, load, div_start, div_done;
  logic               is_zero, is_range, is_mismatch;
  logic [PROD_W-1:0]  dividend, div_quo;
  logic               unused_quo_hi;

  assign is_zero     = (snap_reads == '0);
  assign is_range    = (snap_hits > snap_reads);
  assign is_mismatch = (({1'b0, snap_hits} + {1'b0, snap_misses}) != {1'b0, snap_reads});
  assign dividend    = PROD_W'(snap_hits) * PROD_W'(SCALE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load      = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (is_zero || is_range) begin
          state_d = DONE;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shortcut paths saturate the ratio; the normal path clears it at LOAD and
  // takes the divider result on the final step.
  always_comb begin
    ratio_d = ratio_r;
    if (load) begin
      ratio_d = (!is_zero && is_range) ? RATIO_W'(SCALE) : '0;
    end else if (state_q == DIV && div_done) begin
      ratio_d = div_quo[RATIO_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_hits      <= '0;
      snap_misses    <= '0;
      snap_reads     <= '0;
      ratio_r        <= '0;
      err_zero_r     <= 1'b0;
      err_range_r    <= 1'b0;
      err_mismatch_r <= 1'b0;
    end else begin
      if (capture) begin
        snap_hits   <= bus.hit_cnt;
        snap_misses <= bus.miss_cnt;
        snap_reads  <= bus.read_cnt;
      end
      if (load) begin
        err_zero_r     <= is_zero;
        err_range_r    <= is_range;
        err_mismatch_r <= is_mismatch;
      end
      ratio_r <= ratio_d;
    end
  end

  stats_divider #(
    .CNT_W (CNT_W),
    .PROD_W(PROD_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(dividend),
    .divisor (snap_reads),
    .quotient(div_quo),
    .done    (div_done)
  );

  // Quotient never exceeds SCALE because hits <= reads on this path.
  assign unused_quo_hi = |div_quo[PROD_W-1:RATIO_W];

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.res_valid    = (state_q == DONE);
  assign bus.ratio_bp     = ratio_r;
  assign bus.hits_q       = snap_hits;
  assign bus.misses_q     = snap_misses;
  assign bus.reads_q      = snap_reads;
  assign bus.err_zero     = err_zero_r;
  assign bus.err_range    = err_range_r;
  assign bus.err_mismatch = err_mismatch_r;

`ifdef CACHE_STATS_PRINT_EN
  always @(posedge clk) begin
    if (rst_n && state_q != DONE && state_d == DONE) begin
      $display("cache_stats: reads=%0d hits=%0d misses=%0d ratio=%0d.%02d%%%s%s%s",
               snap_reads, snap_hits, snap_misses, ratio_d / 100, ratio_d % 100,
               is_zero ? " err_zero" : "", is_range ? " err_range" : "",
               is_mismatch ? " err_mismatch" : "");
    end
  end
`else
  // Silent build: no simulation-only reporting.
`endif

endmodule

// File: tb/tb_cache_stats.sv
// tb/tb_cache_stats.sv - scoreboard bench for cache_stats
module tb_cache_stats;
  import cache_stats_pkg::*;

  typedef struct {
    logic [13:0] ratio;
    logic [2:0]  flags;
    logic [95:0] snap;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  cache_stats_if sif ();

  cache_stats dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [31:0] h, input logic [31:0] m, input logic [31:0] r);
    exp_t e;
    logic [63:0] p;
    logic [32:0] sum;
    sum     = 33'(h) + 33'(m);
    e.flags = {r == 32'd0, h > r, sum != 33'(r)};
    e.snap  = {h, m, r};
    if (r == 32'd0) begin
      e.ratio = 14'd0;
      e.lat   = 2;
    end else if (h > r) begin
      e.ratio = 14'd10000;
      e.lat   = 2;
    end else begin
      p       = 64'(h) * 64'd10000;
      e.ratio = 14'(p / 64'(r));
      e.lat   = 48;
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] h, input logic [31:0] m, input logic [31:0] r);
    sb.push_back(model(h, m, r));
    @(negedge clk);
    sif.hit_cnt     = h;
    sif.miss_cnt    = m;
    sif.read_cnt    = r;
    sif.start_valid = 1'b1;
    @(posedge clk);
    #1;
    sif.start_valid = 1'b0;
    sif.hit_cnt     = $urandom;
    sif.miss_cnt    = $urandom;
    sif.read_cnt    = $urandom;
  endtask

  task automatic wait_res(output int edges);
    edges = 1;
    while (sif.res_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release_res;
    @(negedge clk);
    sif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    sif.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    sif.start_valid = 1'b0;
    sif.res_ready   = 1'b0;
    sif.hit_cnt     = '0;
    sif.miss_cnt    = '0;
    sif.read_cnt    = '0;
    #1;
    total++;
    if (sif.start_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset start_ready: got=%b exp=1", sif.start_ready);
    end
    total++;
    if ({sif.res_valid, sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch} !== 18'd0) begin
      bad++;
      $display("FAIL reset outputs: got=%h exp=0",
               {sif.res_valid, sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch});
    end
    total++;
    if ({sif.hits_q, sif.misses_q, sif.reads_q} !== 96'd0) begin
      bad++;
      $display("FAIL reset snapshot: got=%h exp=0", {sif.hits_q, sif.misses_q, sif.reads_q});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag, input logic [31:0] h_t[], input logic [31:0] m_t[],
                           input logic [31:0] r_t[]);
    int   edges;
    exp_t e;
    for (int i = 0; i < h_t.size(); i++) begin
      send(h_t[i], m_t[i], r_t[i]);
      wait_res(edges);
      e = sb.pop_front();
      total++;
      if (edges !== e.lat) begin
        bad++;
        $display("FAIL %s[%0d] latency: got=%0d exp=%0d", tag, i, edges, e.lat);
      end
      total++;
      if (sif.ratio_bp !== e.ratio) begin
        bad++;
        $display("FAIL %s[%0d] ratio: got=%0d exp=%0d", tag, i, sif.ratio_bp, e.ratio);
      end
      total++;
      if ({sif.err_zero, sif.err_range, sif.err_mismatch} !== e.flags) begin
        bad++;
        $display("FAIL %s[%0d] flags: got=%b exp=%b", tag, i,
                 {sif.err_zero, sif.err_range, sif.err_mismatch}, e.flags);
      end
      total++;
      if ({sif.hits_q, sif.misses_q, sif.reads_q} !== e.snap) begin
        bad++;
        $display("FAIL %s[%0d] snapshot: got=%h exp=%h", tag, i,
                 {sif.hits_q, sif.misses_q, sif.reads_q}, e.snap);
      end
      release_res();
    end
  endtask

  task automatic test_normal;
    logic [31:0] h_t[] = '{32'd3, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] m_t[] = '{32'd1, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] r_t[] = '{32'd4, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 4; i < 8; i++) begin
      r_t[i] = $urandom | 32'd1;
      h_t[i] = $urandom_range(r_t[i], 0);
      m_t[i] = i[0] ? (r_t[i] - h_t[i]) : $urandom;
    end
    run_table("normal", h_t, m_t, r_t);
  endtask

  task automatic test_shortcut;
    logic [31:0] h_t[] = '{32'd0, 32'd5, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] m_t[] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] r_t[] = '{32'd0, 32'd4, 32'd0, 32'hFFFF_FFFE};
    run_table("shortcut", h_t, m_t, r_t);
  endtask

  task automatic test_hold;
    int   edges;
    exp_t e;
    send(32'd3, 32'd1, 32'd4);
    wait_res(edges);
    e = sb.pop_front();
    total++;
    if (edges !== e.lat) begin
      bad++;
      $display("FAIL hold latency: got=%0d exp=%0d", edges, e.lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sif.hit_cnt     = $urandom;
      sif.miss_cnt    = $urandom;
      sif.read_cnt    = $urandom;
      sif.start_valid = i[0];
      @(posedge clk);
      #1;
      total++;
      if ({sif.res_valid, sif.start_ready, sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch,
           sif.hits_q, sif.misses_q, sif.reads_q} !== {2'b10, e.ratio, e.flags, e.snap}) begin
        bad++;
        $display("FAIL hold[%0d] stable: got=%h exp=%h", i,
                 {sif.res_valid, sif.start_ready, sif.ratio_bp, sif.err_zero, sif.err_range,
                  sif.err_mismatch, sif.hits_q, sif.misses_q, sif.reads_q},
                 {2'b10, e.ratio, e.flags, e.snap});
      end
    end
    @(negedge clk);
    sif.start_valid = 1'b0;
    sif.res_ready   = 1'b1;
    @(posedge clk);
    #1;
    sif.res_ready = 1'b0;
    total++;
    if ({sif.start_ready, sif.res_valid} !== 2'b10) begin
      bad++;
      $display("FAIL hold release: got=%b exp=10", {sif.start_ready, sif.res_valid});
    end
  endtask

  task automatic test_back_to_back;
    int   edges;
    exp_t e;
    send(32'd1, 32'd2, 32'd3);
    wait_res(edges);
    e = sb.pop_front();
    total++;
    if (sif.ratio_bp !== e.ratio) begin
      bad++;
      $display("FAIL b2b first ratio: got=%0d exp=%0d", sif.ratio_bp, e.ratio);
    end
    @(negedge clk);
    sb.push_back(model(32'd3, 32'd1, 32'd4));
    sif.hit_cnt     = 32'd3;
    sif.miss_cnt    = 32'd1;
    sif.read_cnt    = 32'd4;
    sif.start_valid = 1'b1;
    sif.res_ready   = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({sif.start_ready, sif.res_valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b take: got=%b exp=10", {sif.start_ready, sif.res_valid});
    end
    @(negedge clk);
    sif.res_ready = 1'b0;
    @(posedge clk);
    #1;
    sif.start_valid = 1'b0;
    total++;
    if (sif.start_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b accept: got=%b exp=0", sif.start_ready);
    end
    wait_res(edges);
    e = sb.pop_front();
    total++;
    if (edges !== e.lat) begin
      bad++;
      $display("FAIL b2b second latency: got=%0d exp=%0d", edges, e.lat);
    end
    total++;
    if (sif.ratio_bp !== e.ratio) begin
      bad++;
      $display("FAIL b2b second ratio: got=%0d exp=%0d", sif.ratio_bp, e.ratio);
    end
    release_res();
  endtask

  task automatic test_async_reset;
    int   edges;
    exp_t e;
    send(32'd3, 32'd1, 32'd4);
    edges = 1;
    while (edges < 22) begin
      @(posedge clk);
      #1;
      edges++;
    end
    total++;
    if ({sif.start_ready, sif.res_valid} !== 2'b00) begin
      bad++;
      $display("FAIL areset busy: got=%b exp=00", {sif.start_ready, sif.res_valid});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sif.start_ready !== 1'b1) begin
      bad++;
      $display("FAIL areset start_ready: got=%b exp=1", sif.start_ready);
    end
    total++;
    if ({sif.res_valid, sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch,
         sif.hits_q, sif.misses_q, sif.reads_q} !== 114'd0) begin
      bad++;
      $display("FAIL areset outputs: got=%h exp=0",
               {sif.res_valid, sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch,
                sif.hits_q, sif.misses_q, sif.reads_q});
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd1, 32'd2, 32'd3);
    wait_res(edges);
    e = sb.pop_front();
    total++;
    if (edges !== e.lat) begin
      bad++;
      $display("FAIL areset recover latency: got=%0d exp=%0d", edges, e.lat);
    end
    total++;
    if ({sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch} !== {e.ratio, e.flags}) begin
      bad++;
      $display("FAIL areset recover result: got=%h exp=%h",
               {sif.ratio_bp, sif.err_zero, sif.err_range, sif.err_mismatch}, {e.ratio, e.flags});
    end
    release_res();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_shortcut();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_stats.md
Name: cache_stats

Overview:
- Downstream consumer of the instruction cache's hit, miss and read counters.
- On request, snapshots the three counters and checks them for consistency.
- Computes hit ratio in basis points (hits*SCALE/reads, truncated) with a serial restoring divider.
- Returns the result under a valid/ready handshake to the report/print logic.

Parameters:
- CNT_W, 32: width of each incoming counter.
- SCALE, 10000: ratio scale factor (basis points); must satisfy SCALE < 2**RATIO_W.
- RATIO_W, 14: width of the ratio result.
- PROD_W, CNT_W+RATIO_W (46): width of the hits*SCALE dividend; this is also the divider step count.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to snapshot the counters and compute.
- start_ready  out  1  high only in IDLE.
- hit_cnt  in  CNT_W  cumulative hits.
- miss_cnt  in  CNT_W  cumulative misses.
- read_cnt  in  CNT_W  cumulative reads.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  consumer accepts the result.
- ratio_bp  out  RATIO_W  hit ratio, range 0..SCALE.
- hits_q, misses_q, reads_q  out  CNT_W each  snapshot captured at accept.
- err_zero  out  1  read_cnt was 0.
- err_range  out  1  hit_cnt > read_cnt.
- err_mismatch  out  1  hit_cnt + miss_cnt (CNT_W+1 bits) != read_cnt.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except start_ready=1; step counter and divider registers cleared; an in-flight computation is discarded.
- IDLE: start_ready=1. On start_valid at an edge, capture the three counts into the *_q registers and go to LOAD. Inputs are ignored after capture.
- LOAD (1 cycle):
  - Compute dividend = hits_q*SCALE at PROD_W bits (no overflow by construction).
  - Compute all three error flags.
  - If reads_q==0: ratio_bp=0, err_zero=1, go to DONE.
  - Else if hits_q>reads_q: ratio_bp=SCALE, err_range=1, go to DONE.
  - Else: load the divider and go to DIV.
  - err_mismatch is informational only and does not alter the path.
- DIV:
  - Exactly PROD_W cycles, one quotient bit per cycle, MSB first.
  - Each step: remainder = {remainder, next dividend bit}; if remainder >= reads_q, subtract and set the quotient bit.
  - Remainder width is CNT_W+1.
  - After the last step, ratio_bp = quotient[RATIO_W-1:0]; upper quotient bits are guaranteed 0.
- DONE:
  - res_valid=1; ratio_bp, *_q and err_* are stable.
  - start_valid is ignored.
  - On res_ready at an edge, go to IDLE and clear res_valid. Data outputs hold their last value until the next LOAD.
- Latency from accept edge to res_valid high:
  - normal path: PROD_W+2 = 48 edges;
  - zero/range shortcut: 2 edges.
- Throughput: one request in flight. The next start is accepted the cycle after the result is taken.
- Counter saturation: counters at 2**CNT_W-1 are legal. Arithmetic never wraps.

Optional Feature:
- CACHE_STATS_PRINT_EN defined: on the DONE entry edge, a simulation $display prints reads, hits, misses, ratio as "NN.NN%", and any set error flags.
- Not defined: no display code is compiled; RTL behaviour is identical.

Decomposition:
- Package cache_stats_pkg holds:
  - state enum {IDLE, LOAD, DIV, DONE};
  - default CNT_W, RATIO_W, SCALE constants;
  - PROD_W derivation.
- Sub-module stats_divider holds the serial restoring divider:
  - start, dividend, divisor in; quotient, done out;
  - step counter internal.
- cache_stats owns the FSM, snapshot registers, checks and handshake.

Test Plan:
- hit=3, miss=1, read=4, start pulse -> ratio_bp=7500 exactly 48 edges after accept; no error flags.
- hit=1, miss=2, read=3 -> ratio_bp=3333 (truncated); err_mismatch=0. Repeat with miss=1 -> ratio 3333, err_mismatch=1.
- read=0, hit=0, miss=0 -> ratio_bp=0, err_zero=1, res_valid after 2 edges.
- hit=5, read=4 -> ratio_bp=10000, err_range=1 after 2 edges. Also hit=read=0xFFFFFFFF, miss=0 -> ratio_bp=10000, no flags, 48 edges.
- Hold res_ready=0 for 10 cycles in DONE while toggling the counters and start_valid -> outputs stable, start_ready=0. Then res_ready=1 -> IDLE next edge, start_ready=1.
- Assert rst_n low asynchronously mid-DIV (step 20) -> outputs zero immediately, start_ready=1. After release, a new request computes correctly.
